// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests the word at the current PC, classifies
// it (JMP / HALT / ordinary), hands ordinary words downstream and then
// advances or reloads the PC before fetching again.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] execadd,
  output logic        loadPC,
  output logic        incPC,
  output logic [11:0] address,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;
  localparam logic [2:0] S_STEP    = 3'd5;
  localparam logic [2:0] S_SETTLE  = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [11:0] addr_hold;  // request address frozen for the WAIT phase
  logic        step_jmp;   // STEP should reload (1) or increment (0) the PC

  function automatic logic is_jmp(input logic [15:0] w);
    return w[15:12] == OP_JMP;
  endfunction

  function automatic logic is_halt(input logic [15:0] w);
    return w[15:12] == OP_HALT;
  endfunction

  // Next-state selection; start and mem_ack only matter in IDLE and WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_REQ;
      S_REQ:     state_nxt = S_WAIT;
      S_WAIT:    if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_jmp(instr))       state_nxt = S_STEP;
        else if (is_halt(instr)) state_nxt = S_HALT;
        else                     state_nxt = S_DELIVER;
      end
      S_DELIVER: if (instr_ready) state_nxt = S_STEP;
      S_STEP:    state_nxt = S_SETTLE;
      S_SETTLE:  state_nxt = S_REQ;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register; reset wins in every state, abandoning any open request.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Fetch datapath: request address, captured word, jump target, fetch count.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold   <= 12'd0;
      instr       <= 16'd0;
      address     <= 12'd0;
      step_jmp    <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      if (state == S_REQ) addr_hold <= execadd;
      if (state == S_WAIT && mem_ack) begin
        instr       <= mem_rdata;
        fetch_count <= fetch_count + 16'd1;
      end
      if (state == S_DECODE) begin
        step_jmp <= is_jmp(instr);
        if (is_jmp(instr)) address <= instr[11:0];
      end
    end
  end

  // PC update pulses: one registered cycle leaving STEP, mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      loadPC <= 1'b0;
      incPC  <= 1'b0;
    end else begin
      loadPC <= (state == S_STEP) &&  step_jmp;
      incPC  <= (state == S_STEP) && !step_jmp;
    end
  end

  // In REQ the address comes straight from the PC so a just-settled update is
  // seen at once; it is then held from the register until the ack arrives.
  always_comb begin
    mem_req     = (state == S_REQ) || (state == S_WAIT);
    mem_addr    = (state == S_REQ) ? execadd : addr_hold;
    instr_valid = (state == S_DELIVER);
    halted      = (state == S_HALT);
  end

endmodule
